// File: rtl/decode_if.sv
// decode_if: upstream instruction and downstream decoded-entry handshake bundle
interface decode_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [INSTR_W-1:0]       in_instr;
  logic [PC_W-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [4:0]               out_rs;
  logic [4:0]               out_rt;
  logic [4:0]               out_rd;
  logic [4:0]               out_shamt;
  logic [5:0]               out_opcode;
  logic [5:0]               out_funct;
  logic [31:0]              out_imm;
  logic [PC_W-1:0]          out_jtarget;
  logic [PC_W-1:0]          out_pc;
  logic [1:0]               out_class;
  logic [$clog2(DEPTH):0]   out_count;
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_rs, out_rt, out_rd, out_shamt, out_opcode,
           out_funct, out_imm, out_jtarget, out_pc, out_class, out_count
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_rs, out_rt, out_rd, out_shamt, out_opcode,
           out_funct, out_imm, out_jtarget, out_pc, out_class, out_count
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: decodes instructions on entry and queues decoded entries for downstream
module decode_stage #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  decode_if.slave     bus,
  output logic [31:0] retired
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  if (INSTR_W != 32) begin : g_bad_instr_w
    $error("decode_stage: INSTR_W must be 32");
  end
  if (PC_W < 28) begin : g_bad_pc_w
    $error("decode_stage: PC_W must be at least 28");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_stage: DEPTH must be a power of two and at least 2");
  end
  typedef struct packed {
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [31:0]     imm;
    logic [PC_W-1:0] jtarget;
    logic [PC_W-1:0] pc;
    logic [1:0]      cls;
  } entry_t;
  entry_t          mem_q [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     retired_q, retired_d;
  logic [PC_W-1:0] pc4;
  logic            push, pop;
  // Upper jump-target bits come from PC+4; the low 28 bits are the shifted index.
  localparam logic [PC_W-1:0] HI_MASK = ~PC_W'(28'hFFF_FFFF);
  always_comb begin
    pc4         = bus.in_pc + PC_W'(4);
    dec.opcode  = bus.in_instr[31:26];
    dec.rs      = bus.in_instr[25:21];
    dec.rt      = bus.in_instr[20:16];
    dec.rd      = bus.in_instr[15:11];
    dec.shamt   = bus.in_instr[10:6];
    dec.funct   = bus.in_instr[5:0];
    dec.imm     = (bus.in_instr[31:28] == 4'b0011) ? {16'b0, bus.in_instr[15:0]}
                                                   : {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
    dec.jtarget = (pc4 & HI_MASK) | PC_W'({bus.in_instr[25:0], 2'b00});
    dec.pc      = bus.in_pc;
    dec.cls     = (bus.in_instr[31:26] == 6'h00) ? 2'b00 :
                  (bus.in_instr[31:27] == 5'b00001) ? 2'b10 : 2'b01;
  end
  assign bus.in_ready  = !rst && (count_q != CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid && bus.in_ready && !flush;
  assign pop           = bus.out_valid && bus.out_ready && !flush;
  always_comb begin
    wptr_d    = flush ? '0 : wptr_q + AW'(push);
    rptr_d    = flush ? '0 : rptr_q + AW'(pop);
    count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
    retired_d = retired_q + 32'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      retired_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      retired_q <= retired_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dec;
  end
  assign head            = bus.out_valid ? mem_q[rptr_q] : '0;
  assign bus.out_rs      = head.rs;
  assign bus.out_rt      = head.rt;
  assign bus.out_rd      = head.rd;
  assign bus.out_shamt   = head.shamt;
  assign bus.out_opcode  = head.opcode;
  assign bus.out_funct   = head.funct;
  assign bus.out_imm     = head.imm;
  assign bus.out_jtarget = head.jtarget;
  assign bus.out_pc      = head.pc;
  assign bus.out_class   = head.cls;
  assign bus.out_count   = count_q;
  assign retired         = retired_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decoding, queueing, backpressure, flush and reset
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] retired;
  int          checks = 0;
  int          errors = 0;
  decode_if #(.INSTR_W(32), .PC_W(32), .DEPTH(2)) bus ();
  decode_stage #(.INSTR_W(32), .PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    step();
    chk("rst_count", 64'(bus.out_count), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_fields_zero", 64'(bus.out_rs), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    // R-type
    drive(1'b1, 32'h012A4020, 32'h00400000);
    chk("no_bypass", 64'(bus.out_valid), 64'd0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("r_valid", 64'(bus.out_valid), 64'd1);
    chk("r_rs", 64'(bus.out_rs), 64'd9);
    chk("r_rt", 64'(bus.out_rt), 64'd10);
    chk("r_rd", 64'(bus.out_rd), 64'd8);
    chk("r_shamt", 64'(bus.out_shamt), 64'd0);
    chk("r_funct", 64'(bus.out_funct), 64'h20);
    chk("r_class", 64'(bus.out_class), 64'd0);
    chk("r_pc", 64'(bus.out_pc), 64'h00400000);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("r_pop_count", 64'(bus.out_count), 64'd0);
    chk("r_pop_retired", 64'(retired), 64'd1);
    // Immediate extension
    drive(1'b1, 32'h3C01FFFF, 32'h00000010);
    step();
    drive(1'b1, 32'h2021FFFF, 32'h00000014);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("ext_count", 64'(bus.out_count), 64'd2);
    chk("ext_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("ext_zext_imm", 64'(bus.out_imm), 64'h0000FFFF);
    chk("ext_lui_class", 64'(bus.out_class), 64'd1);
    chk("ext_lui_opcode", 64'(bus.out_opcode), 64'h0F);
    bus.out_ready = 1'b1;
    step();
    chk("ext_sext_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
    chk("ext_retired", 64'(retired), 64'd2);
    step();
    bus.out_ready = 1'b0;
    chk("ext_empty", 64'(bus.out_count), 64'd0);
    chk("ext_retired2", 64'(retired), 64'd3);
    // Jump targets, including PC+4 wrap
    drive(1'b1, 32'h08000010, 32'h40000000);
    step();
    chk("j_target", 64'(bus.out_jtarget), 64'h40000040);
    chk("j_class", 64'(bus.out_class), 64'd2);
    drive(1'b1, 32'h0C000010, 32'hFFFFFFFC);
    step();
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    step();
    chk("jal_wrap_target", 64'(bus.out_jtarget), 64'h00000040);
    chk("jal_class", 64'(bus.out_class), 64'd2);
    chk("j_retired", 64'(retired), 64'd4);
    step();
    bus.out_ready = 1'b0;
    chk("j_retired2", 64'(retired), 64'd5);
    // Backpressure: third push must be refused
    drive(1'b1, 32'h012A4020, 32'h00000100);
    step();
    drive(1'b1, 32'h3C01FFFF, 32'h00000104);
    step();
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h2021FFFF, 32'h00000108);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_count", 64'(bus.out_count), 64'd2);
    chk("bp_head_pc_stable", 64'(bus.out_pc), 64'h100);
    chk("bp_head_rs_stable", 64'(bus.out_rs), 64'd9);
    bus.out_ready = 1'b1;
    step();
    chk("bp_order_pc", 64'(bus.out_pc), 64'h104);
    chk("bp_count1", 64'(bus.out_count), 64'd1);
    step();
    bus.out_ready = 1'b0;
    chk("bp_retired", 64'(retired), 64'd7);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);
    // Simultaneous push and pop
    drive(1'b1, 32'h012A4020, 32'h00000200);
    step();
    drive(1'b1, 32'h2021FFFF, 32'h00000204);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pp_count", 64'(bus.out_count), 64'd1);
    chk("pp_head_pc", 64'(bus.out_pc), 64'h204);
    chk("pp_retired", 64'(retired), 64'd8);
    drive(1'b1, 32'h3C01FFFF, 32'h00000208);
    step();
    chk("fl_pre_count", 64'(bus.out_count), 64'd2);
    // Flush with full queue, pending input and pending pop
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h012A4020, 32'h0000020C);
    step();
    chk("fl_count", 64'(bus.out_count), 64'd0);
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_retired", 64'(retired), 64'd8);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    chk("fl_drop_input", 64'(bus.out_count), 64'd0);
    chk("fl_fields_zero", 64'(bus.out_pc), 64'd0);
    // Reset mid-stream, asserted together with flush
    drive(1'b1, 32'h012A4020, 32'h00000300);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("mr_count", 64'(bus.out_count), 64'd1);
    rst = 1'b1;
    flush = 1'b1;
    step();
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_retired", 64'(retired), 64'd0);
    chk("mr_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    flush = 1'b0;
    step();
    chk("mr_post_in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'h08000010, 32'h40000000);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("mr_ptr_restart", 64'(bus.out_jtarget), 64'h40000040);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
- REQ-001 Parameter: INSTR_W, 32, instruction width; only 32 is supported and any other value SHALL fail elaboration.
- REQ-002 Parameter: PC_W, 32, program-counter width; must be at least 28.
- REQ-003 Parameter: DEPTH, 2, decoded-entry queue depth; power of two and at least 2.
- REQ-004 Port: clk, input, 1, single clock; all state updates on the rising edge.
- REQ-005 Port: rst, input, 1, reset; synchronous and active-high.
- REQ-006 Port: flush, input, 1, discards all queued entries.
- REQ-007 Port: in_valid / in_ready, input / output, 1 each, upstream handshake.
- REQ-008 Port: in_instr, input, INSTR_W, raw instruction.
- REQ-009 Port: in_pc, input, PC_W, PC of the instruction.
- REQ-010 Port: out_valid / out_ready, output / input, 1 each, downstream handshake.
- REQ-011 Port: out_rs, out_rt, out_rd, out_shamt, output, 5 each, fields from bits [25:21], [20:16], [15:11], [10:6].
- REQ-012 Port: out_opcode, out_funct, output, 6 each, fields from bits [31:26] and [5:0].
- REQ-013 Port: out_imm, output, 32, extended immediate.
- REQ-014 Port: out_jtarget, output, PC_W, jump target.
- REQ-015 Port: out_pc, output, PC_W, PC carried with the entry.
- REQ-016 Port: out_class, output, 2, instruction class: 00 = R, 01 = I, 10 = J.
- REQ-017 Port: out_count, output, clog2(DEPTH)+1, number of occupied entries.
- REQ-018 Port: retired, output, 32, count of output handshakes.

Function
- REQ-019 Accept condition: an input is accepted when in_valid & in_ready & !flush.
- REQ-020 in_ready SHALL be (out_count != DEPTH) and SHALL have no combinational path from out_ready.
- REQ-021 Decoding SHALL happen on the input side; the queue SHALL store fully decoded entries.
- REQ-022 Latency: an entry accepted in cycle N SHALL appear on the outputs in cycle N+1 at the earliest; there is no bypass.
- REQ-023 out_valid SHALL be (out_count != 0); output fields SHALL show the head entry.
- REQ-024 While out_valid=1 and out_ready=0, every output field SHALL stay stable.
- REQ-025 A pop SHALL occur when out_valid & out_ready.
- REQ-026 Push and pop in the same cycle SHALL leave out_count unchanged.
- REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
- REQ-028 out_imm SHALL be zero-extended when opcode is 0x0C, 0x0D, 0x0E or 0x0F; otherwise it SHALL be sign-extended from instr[15:0].
- REQ-029 out_jtarget SHALL equal {(in_pc+4)[PC_W-1:28], instr[25:0], 2'b00}, with the PC+4 add wrapping modulo 2^PC_W.
- REQ-030 out_class SHALL be 00 for opcode 0x00, 10 for opcode 0x02 or 0x03, and 01 otherwise.
- REQ-031 Flush SHALL take priority: empty the queue next cycle, drop any same-cycle input, and block any pop in that cycle.
- REQ-032 A flush SHALL NOT increment retired.
- REQ-033 retired SHALL increment by 1 per pop and wrap from 0xFFFFFFFF to 0.

Reset
- REQ-034 While rst=1, the block SHALL set out_count=0, out_valid=0, in_ready=0, retired=0, and reset both pointers to 0.
- REQ-035 The cycle after rst is released, in_ready SHALL be 1.
- REQ-036 Queue data contents need no reset value, but output fields SHALL read as 0 while out_valid=0.
- REQ-037 rst asserted mid-operation SHALL discard all entries within one cycle, and rst SHALL override flush.

Verification
- REQ-038 R-type: instr=0x012A4020, pc=0x00400000 -> next cycle rs=9, rt=10, rd=8, shamt=0, funct=0x20, class=00.
- REQ-039 Extension: instr 0x3C01FFFF gives imm=0x0000FFFF and class=01; instr 0x2021FFFF gives imm=0xFFFFFFFF.
- REQ-040 Jump: instr=0x08000010, pc=0x40000000 -> jtarget=0x40000040, class=10.
- REQ-041 Backpressure: hold out_ready=0 and push 3 instructions -> in_ready=0 after 2 pushes, count=2, head fields stable; then out_ready=1 -> entries come out in order and retired=2.
- REQ-042 Simultaneous events: full queue with flush=1 and in_valid=1 in the same cycle -> next cycle count=0 and out_valid=0, with retired unchanged.
- REQ-043 Reset mid-stream: rst pulsed with count=1 -> out_valid=0 and retired=0 the next cycle.
